// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that turns 32-bit words from two requesters into
// 10-byte ASCII packets (header, 8 hex chars MSB first, terminator) on the uart_tx write port.
module uart_tx_word_arbiter #(
   parameter logic [7:0] HDR0 = 8'h41,
   parameter logic [7:0] HDR1 = 8'h42,
   parameter logic [7:0] TERM = 8'h0A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   input  logic        tx_fifo_full,
   output logic        tx_write_en,
   output logic [7:0]  tx_din,
   output logic        busy,
   output logic        grant_id,
   output logic        pkt_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_HEX,
      S_TERM
   } state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [31:0] word;
   logic        prio;
   logic        granted;
   logic        accept;
   logic [3:0]  nibble;

   // With both requesters waiting the pointer decides; otherwise whoever is valid wins.
   always_comb begin
      granted = 1'b0;
      if (req0_valid && req1_valid) begin
         granted = prio;
      end else begin
         granted = req1_valid;
      end
   end

   assign req0_ready  = (state == S_IDLE) && !rst && req0_valid && !granted;
   assign req1_ready  = (state == S_IDLE) && !rst && req1_valid && granted;
   assign accept      = req0_ready || req1_ready;
   assign busy        = (state != S_IDLE);
   assign tx_write_en = busy && !tx_fifo_full && !rst;

   // ~cnt equals 7 - cnt, so nibble 7 (the MSB) goes out first.
   assign nibble = word[{~cnt, 2'b00} +: 4];

   always_comb begin
      tx_din = 8'h00;
      case (state)
         S_HDR:  tx_din = grant_id ? HDR1 : HDR0;
         S_HEX:  tx_din = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                           : (8'h37 + {4'h0, nibble});
         S_TERM: tx_din = TERM;
         default: tx_din = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 3'd0;
         word     <= 32'h0;
         grant_id <= 1'b0;
         prio     <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  word     <= granted ? req1_data : req0_data;
                  grant_id <= granted;
                  cnt      <= 3'd0;
                  state    <= S_HDR;
               end
            end
            S_HDR: begin
               if (tx_write_en) begin
                  state <= S_HEX;
               end
            end
            S_HEX: begin
               if (tx_write_en) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     state <= S_TERM;
                  end
               end
            end
            S_TERM: begin
               if (tx_write_en) begin
                  state    <= S_IDLE;
                  pkt_done <= 1'b1;
                  prio     <= ~grant_id;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Directed bench for uart_tx_word_arbiter: byte streams, round-robin order,
// backpressure, reset mid-packet and a random handshake-hygiene run.
module tb_uart_tx_word_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        tx_fifo_full;
   logic        tx_write_en;
   logic [7:0]  tx_din;
   logic        busy;
   logic        grant_id;
   logic        pkt_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   string hex_digits = "0123456789ABCDEF";

   uart_tx_word_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .tx_fifo_full (tx_fifo_full),
      .tx_write_en  (tx_write_en),
      .tx_din       (tx_din),
      .busy         (busy),
      .grant_id     (grant_id),
      .pkt_done     (pkt_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Walks one packet byte by byte; optionally stalls with the FIFO full before byte stall_at,
   // and stops after n_bytes so a packet can be cut short.
   task automatic apply_stimulus(input logic [7:0] hdr, input logic [31:0] word,
                                 input int stall_at, input int stall_len, input int n_bytes);
      logic [7:0] bytes [10];
      logic [3:0] nib;
      bytes[0] = hdr;
      for (int j = 0; j < 8; j++) begin
         nib = word[28 - 4*j +: 4];
         bytes[j+1] = hex_digits[int'(nib)];
      end
      bytes[9] = 8'h0A;
      for (int i = 0; i < n_bytes; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               tx_fifo_full = 1'b1;
               #1;
               check_output("stall_we", tx_write_en, 0);
               check_output("stall_din", tx_din, bytes[i]);
               check_output("stall_busy", busy, 1);
               tick;
            end
            tx_fifo_full = 1'b0;
         end
         #1;
         check_output($sformatf("byte%0d_we", i), tx_write_en, 1);
         check_output($sformatf("byte%0d_din", i), tx_din, bytes[i]);
         check_output("ready_while_busy", {req0_ready, req1_ready}, 0);
         check_output("pkt_done_mid", pkt_done, 0);
         tick;
      end
   endtask

   initial begin
      int acc_prev;
      int drain;
      logic [31:0] words [3];

      rst          = 1'b1;
      req0_valid   = 1'b0;
      req0_data    = 32'h0;
      req1_valid   = 1'b0;
      req1_data    = 32'h0;
      tx_fifo_full = 1'b0;

      $display("[TB] reset");
      tick;
      #1;
      check_output("rst_we", tx_write_en, 0);
      check_output("rst_busy", busy, 0);
      tick;
      rst = 1'b0;
      #1;
      check_output("idle_busy", busy, 0);
      check_output("idle_grant", grant_id, 0);
      check_output("idle_pkt_done", pkt_done, 0);
      check_output("idle_din", tx_din, 8'h00);
      check_output("idle_we", tx_write_en, 0);

      $display("[TB] single word");
      req0_valid = 1'b1;
      req0_data  = 32'h12AB_09FF;
      #1;
      check_output("single_ready", {req0_ready, req1_ready}, 2'b10);
      acc_prev = cyc;
      tick;
      req0_valid = 1'b0;
      apply_stimulus(8'h41, 32'h12AB_09FF, -1, 0, 10);
      #1;
      check_output("single_pkt_done", pkt_done, 1);
      check_output("single_done_lat", cyc - acc_prev, 11);
      check_output("single_busy_after", busy, 0);
      check_output("single_grant", grant_id, 0);
      tick;
      #1;
      check_output("single_pkt_done_off", pkt_done, 0);

      $display("[TB] contention");
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 32'h0;
      req1_valid = 1'b1;
      req1_data  = 32'hFFFF_FFFF;
      for (int p = 0; p < 4; p++) begin
         #1;
         check_output($sformatf("cont%0d_ready", p), {req0_ready, req1_ready},
                      (p % 2 == 0) ? 2'b10 : 2'b01);
         if (p > 0) check_output($sformatf("cont%0d_pkt_done", p), pkt_done, 1);
         tick;
         #1;
         check_output($sformatf("cont%0d_grant", p), grant_id, p % 2);
         apply_stimulus((p % 2 == 0) ? 8'h41 : 8'h42,
                        (p % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF, -1, 0, 10);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      check_output("cont_last_pkt_done", pkt_done, 1);

      $display("[TB] backpressure");
      tick;
      req0_valid = 1'b1;
      req0_data  = 32'hDEAD_BEEF;
      #1;
      check_output("bp_ready", {req0_ready, req1_ready}, 2'b10);
      tick;
      req0_valid = 1'b0;
      apply_stimulus(8'h41, 32'hDEAD_BEEF, 4, 5, 10);
      #1;
      check_output("bp_pkt_done", pkt_done, 1);

      $display("[TB] single requester back-to-back");
      words[0] = 32'hCAFE_0001;
      words[1] = 32'h0000_BEE2;
      words[2] = 32'h7654_3210;
      req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req1_data = words[k];
         #1;
         check_output($sformatf("b2b%0d_ready", k), {req0_ready, req1_ready}, 2'b01);
         if (k > 0) begin
            check_output($sformatf("b2b%0d_spacing", k), cyc - acc_prev, 11);
            check_output($sformatf("b2b%0d_pkt_done", k), pkt_done, 1);
         end
         acc_prev = cyc;
         tick;
         apply_stimulus(8'h42, words[k], -1, 0, 10);
      end
      req1_valid = 1'b0;
      #1;
      check_output("b2b_last_pkt_done", pkt_done, 1);
      tick;

      $display("[TB] reset mid-packet");
      req0_valid = 1'b1;
      req0_data  = 32'h1357_2468;
      #1;
      check_output("rmid_ready", {req0_ready, req1_ready}, 2'b10);
      tick;
      req0_valid = 1'b0;
      apply_stimulus(8'h41, 32'h1357_2468, -1, 0, 4);
      rst        = 1'b1;
      req1_valid = 1'b1;
      req1_data  = 32'h0F1E_2D3C;
      #1;
      check_output("rmid_rst_we", tx_write_en, 0);
      check_output("rmid_rst_ready", {req0_ready, req1_ready}, 0);
      tick;
      rst = 1'b0;
      #1;
      check_output("rmid_busy", busy, 0);
      check_output("rmid_grant_reset", grant_id, 0);
      check_output("rmid_pkt_done", pkt_done, 0);
      check_output("rmid_req1_first", {req0_ready, req1_ready}, 2'b01);
      tick;
      req1_valid = 1'b0;
      #1;
      check_output("rmid_grant1", grant_id, 1);
      apply_stimulus(8'h42, 32'h0F1E_2D3C, -1, 0, 10);
      #1;
      check_output("rmid_done", pkt_done, 1);

      $display("[TB] random hygiene run");
      for (int c = 0; c < 400; c++) begin
         req0_valid   = $urandom_range(0, 1) == 1;
         req1_valid   = $urandom_range(0, 1) == 1;
         req0_data    = $urandom;
         req1_data    = $urandom;
         tx_fifo_full = $urandom_range(0, 3) == 0;
         #1;
         check_output("rnd_both_ready", req0_ready & req1_ready, 0);
         check_output("rnd_ready_busy", busy & (req0_ready | req1_ready), 0);
         check_output("rnd_write_full", tx_fifo_full & tx_write_en, 0);
         tick;
      end
      req0_valid   = 1'b0;
      req1_valid   = 1'b0;
      tx_fifo_full = 1'b0;
      drain = 0;
      while (busy && drain < 40) begin
         tick;
         drain++;
      end
      #1;
      check_output("rnd_drain_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_word_arbiter.md
Name: uart_tx_word_arbiter

Overview:
- Shares the single uart_tx write port (write_en / tx_din / tx_fifo_full) between two 32-bit word requesters, e.g. the DNN result reporter and a debug/status source.
- Each accepted word becomes a 10-byte ASCII packet: header char, 8 uppercase hex chars (MSB nibble first), terminator.
- Grants alternate round-robin. The block never writes while the tx FIFO reports full.
- Sits between the DNN-side producers and the uart_tx instance inside the IO expansion top.

Parameters:
- HDR0, 8'h41, header byte for requester 0 ('A')
- HDR1, 8'h42, header byte for requester 1 ('B')
- TERM, 8'h0A, packet terminator byte (LF)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has a word
- req0_data  input  32  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 has a word
- req1_data  input  32  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle
- tx_fifo_full  input  1  uart_tx FIFO full; no write may be issued
- tx_write_en  output  1  write strobe to uart_tx
- tx_din  output  8  byte to uart_tx
- busy  output  1  packet in progress (state != IDLE)
- grant_id  output  1  owner of the current/last packet
- pkt_done  output  1  one-cycle pulse after the terminator byte is written

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates on posedge clk.
- States and transitions:
  - IDLE -> HDR on acceptance.
  - HDR -> HEX on write.
  - HEX -> TERM after nibble 7 is written.
  - TERM -> IDLE on write.
- Reset:
  - State = IDLE, nibble counter = 0, latched word = 0, grant_id = 0, priority pointer = requester 0, pkt_done = 0.
  - tx_write_en, req0_ready and req1_ready are forced to 0 during any rst cycle regardless of state.
  - Reset mid-packet abandons the remaining bytes. Bytes already written stay written; the bench must not expect the tail.
- Arbitration (IDLE only):
  - Only one valid: grant that requester.
  - Both valid: grant the requester named by the priority pointer.
  - reqN_ready is combinational = (state==IDLE) && !rst && reqN_valid && (granted==N). At most one ready per cycle.
  - On valid&&ready: latch data, set grant_id = N, enter HDR next cycle.
  - Requesters must hold valid/data until ready; a deasserted valid before ready is not an error.
- Priority pointer: on the TERM write, set to the requester that did not own the packet. If only one requester is active it is served back-to-back.
- Byte emission (HDR, HEX, TERM):
  - tx_write_en is combinational = !tx_fifo_full && !rst.
  - tx_din is combinational:
    - HDR: HDR0 or HDR1 per grant_id.
    - HEX: hex char of nibble (7 - cnt) of the latched word. Values 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
    - TERM: TERM.
  - IDLE: tx_write_en = 0, tx_din = 8'h00.
  - The state/counter advances only in cycles where tx_write_en = 1. While tx_fifo_full = 1 the byte is held unchanged, so no byte is lost or duplicated.
- Counter: 3-bit nibble counter, cleared on entering HDR, incremented on each HEX write. On the HEX write with cnt==7 the state moves to TERM (counter wraps to 0).
- pkt_done: registered; 1 for exactly the cycle after the TERM write, 0 otherwise.
- busy: = (state != IDLE).
- Latency:
  - Acceptance cycle plus 10 write cycles: the header is written in the cycle after acceptance, the terminator 10 cycles after acceptance.
  - Next acceptance is possible at the earliest in the cycle after the TERM write, the same cycle pkt_done is high.
  - Minimum 11 cycles per packet with no backpressure.
- Simultaneous events:
  - A new valid during a packet waits; ready stays low until IDLE.
  - tx_fifo_full rising on the TERM cycle delays TERM, pkt_done and the pointer update together.

Test Plan:
- Single word: rst 2 cycles, req0_valid with req0_data=32'h12AB_09FF, full=0 -> exact bytes 41 31 32 41 42 30 39 46 46 0A on consecutive cycles; pkt_done pulses once, 11 cycles after acceptance.
- Contention: req0 and req1 both valid continuously (req0=32'h0, req1=32'hFFFF_FFFF) -> packets alternate A,B,A,B starting with A; header 42 is followed by eight 0x46 bytes.
- Backpressure: during packet 32'hDEADBEEF, hold tx_fifo_full=1 for 5 cycles at nibble 3 -> tx_write_en=0 and tx_din held at 0x44 for those cycles; the full 10-byte stream is unchanged, with no dup or drop.
- Single active requester: req1 only, 3 words back-to-back -> three B packets, each acceptance 11 cycles apart; req0_ready never asserts.
- Reset mid-packet: assert rst during the 4th HEX byte -> no write or ready in the rst cycle; busy=0 the cycle after; the next req1 request is granted first, because the pointer reset to 0 and req0 is idle.
- Handshake hygiene: valid asserted while busy -> ready stays 0 until IDLE, and is never high for both requesters in the same cycle (assertion over a random run).
